// File: rtl/rrg_pkg.sv
// Shared codes, status encodings and FSM state encoding for the ramp/rate
// generator parameter loader.
package rrg_pkg;

    localparam logic [15:0] RRG_CODE_IDLE   = 16'd0;
    localparam logic [15:0] RRG_CODE_Y      = 16'd1;
    localparam logic [15:0] RRG_CODE_R      = 16'd2;
    localparam logic [15:0] RRG_CODE_RI     = 16'd3;
    localparam logic [15:0] RRG_CODE_RO     = 16'd4;
    localparam logic [15:0] RRG_CODE_COMMIT = 16'd5;

    localparam logic [1:0] RRG_ST_OK        = 2'b00;
    localparam logic [1:0] RRG_ST_PARAM_ERR = 2'b01;
    localparam logic [1:0] RRG_ST_ABORTED   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_Y     = 3'd1,
        S_LD_R     = 3'd2,
        S_LD_RI    = 3'd3,
        S_LD_RO    = 3'd4,
        S_COMMIT   = 3'd5,
        S_GAP      = 3'd6,
        S_DONE_ERR = 3'd7
    } rrg_state_e;

    // A set is unusable when the rate increment is negative or the decrement is not positive.
    function automatic logic rrg_params_bad(input logic riset_msb, input logic [63:0] roset);
        return riset_msb | roset[63] | (roset == 64'd0);
    endfunction

endpackage

// File: rtl/rrg_pulse_gen.sv
// Free-running timepulse strobe: one-cycle pulse every PULSE_DIV enabled cycles,
// restarting from zero whenever the enable drops.
module rrg_pulse_gen
#(
    parameter int PULSE_DIV = 100
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_pulse
);

    localparam int CW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // Divider counter; the strobe is registered in the same edge the counter wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (r_cnt == CW'(PULSE_DIV - 1)) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/rrg_param_loader.sv
// Loads one ramp parameter set into the generator by walking codes 1..5 then 0
// on reg_control, holding each code/data word for HOLD_CYCLES clocks.
module rrg_param_loader
    import rrg_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int PULSE_DIV   = 100
)(
    input  logic        clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_yset,
    input  logic [63:0] cmd_rset,
    input  logic [63:0] cmd_riset,
    input  logic [63:0] cmd_roset,
    input  logic        cmd_abort,
    output logic [15:0] reg_control,
    output logic [15:0] reg_0,
    output logic [15:0] reg_1,
    output logic [15:0] reg_2,
    output logic [15:0] reg_3,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    input  logic        pulse_en,
    output logic        timepulse
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    rrg_state_e        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [15:0]       r_code;
    logic [63:0]       r_data;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_status;
    logic              r_aborted;
    logic [63:0]       r_rset;
    logic [63:0]       r_riset;
    logic [63:0]       r_roset;

    logic              w_hold_last;
    rrg_state_e        w_adv_state;
    logic [15:0]       w_adv_code;
    logic [63:0]       w_adv_data;

    assign w_hold_last = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

    // Where each hold-timed state goes when its hold window expires, and what it then drives.
    always_comb begin
        w_adv_state = S_IDLE;
        w_adv_code  = RRG_CODE_IDLE;
        w_adv_data  = 64'd0;
        case (r_state)
            S_LD_Y: begin
                w_adv_state = S_LD_R;
                w_adv_code  = RRG_CODE_R;
                w_adv_data  = r_rset;
            end
            S_LD_R: begin
                w_adv_state = S_LD_RI;
                w_adv_code  = RRG_CODE_RI;
                w_adv_data  = r_riset;
            end
            S_LD_RI: begin
                w_adv_state = S_LD_RO;
                w_adv_code  = RRG_CODE_RO;
                w_adv_data  = r_roset;
            end
            S_LD_RO: begin
                w_adv_state = S_COMMIT;
                w_adv_code  = RRG_CODE_COMMIT;
                w_adv_data  = r_data;
            end
            S_COMMIT: begin
                w_adv_state = S_GAP;
                w_adv_code  = RRG_CODE_IDLE;
                w_adv_data  = 64'd0;
            end
            default: begin
                w_adv_state = S_IDLE;
                w_adv_code  = RRG_CODE_IDLE;
                w_adv_data  = 64'd0;
            end
        endcase
    end

    // Load sequencer FSM with registered code/data/handshake outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_code    <= RRG_CODE_IDLE;
            r_data    <= 64'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_status  <= RRG_ST_OK;
            r_aborted <= 1'b0;
            r_rset    <= 64'd0;
            r_riset   <= 64'd0;
            r_roset   <= 64'd0;
        end else begin
            r_done   <= 1'b0;
            r_status <= RRG_ST_OK;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // yset goes straight into the data register, which holds it through LD_Y.
                        r_rset    <= cmd_rset;
                        r_riset   <= cmd_riset;
                        r_roset   <= cmd_roset;
                        r_hold    <= '0;
                        r_aborted <= 1'b0;
                        r_busy    <= 1'b1;
                        if (rrg_params_bad(cmd_riset[63], cmd_roset)) begin
                            r_state  <= S_DONE_ERR;
                            r_done   <= 1'b1;
                            r_status <= RRG_ST_PARAM_ERR;
                        end else begin
                            r_state <= S_LD_Y;
                            r_code  <= RRG_CODE_Y;
                            r_data  <= cmd_yset;
                        end
                    end
                end
                S_LD_Y, S_LD_R, S_LD_RI, S_LD_RO: begin
                    if (cmd_abort) begin
                        r_state   <= S_GAP;
                        r_hold    <= '0;
                        r_aborted <= 1'b1;
                        r_code    <= RRG_CODE_IDLE;
                        r_data    <= 64'd0;
                    end else if (w_hold_last) begin
                        r_state <= w_adv_state;
                        r_hold  <= '0;
                        r_code  <= w_adv_code;
                        r_data  <= w_adv_data;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (w_hold_last) begin
                        r_state <= w_adv_state;
                        r_hold  <= '0;
                        r_code  <= w_adv_code;
                        r_data  <= w_adv_data;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_hold_last) begin
                        r_state  <= S_IDLE;
                        r_hold   <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_status <= r_aborted ? RRG_ST_ABORTED : RRG_ST_OK;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_DONE_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= '0;
                    r_busy  <= 1'b0;
                    r_code  <= RRG_CODE_IDLE;
                    r_data  <= 64'd0;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE) && !Reset;
    assign reg_control = r_code;
    assign reg_0       = r_data[15:0];
    assign reg_1       = r_data[31:16];
    assign reg_2       = r_data[47:32];
    assign reg_3       = r_data[63:48];
    assign busy        = r_busy;
    assign done        = r_done;
    assign status      = r_status;

    rrg_pulse_gen #(
        .PULSE_DIV (PULSE_DIV)
    ) u_pulse (
        .i_clk   (clk),
        .i_rst   (Reset),
        .i_en    (pulse_en),
        .o_pulse (timepulse)
    );

endmodule

// File: tb/tb_rrg_param_loader.sv
// Self-checking bench for rrg_param_loader: a cycle-level expectation queue
// built from the load-sequence rules, plus directed literal checks.
module tb_rrg_param_loader;

    localparam int H  = 4;
    localparam int PD = 10;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_yset = 64'd0;
    logic [63:0] cmd_rset = 64'd0;
    logic [63:0] cmd_riset = 64'd0;
    logic [63:0] cmd_roset = 64'd0;
    logic        cmd_abort = 1'b0;
    logic [15:0] reg_control, reg_0, reg_1, reg_2, reg_3;
    logic        busy, done;
    logic [1:0]  status;
    logic        pulse_en = 1'b0;
    logic        timepulse;

    int n_cmp = 0;
    int n_err = 0;

    rrg_param_loader #(.HOLD_CYCLES(H), .PULSE_DIV(PD)) dut (
        .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_yset(cmd_yset), .cmd_rset(cmd_rset), .cmd_riset(cmd_riset),
        .cmd_roset(cmd_roset), .cmd_abort(cmd_abort), .reg_control(reg_control),
        .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
        .busy(busy), .done(done), .status(status),
        .pulse_en(pulse_en), .timepulse(timepulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] code;
        logic [63:0] data;
        logic        busy;
        logic        done;
        logic [1:0]  status;
        logic        ready;
    } exp_t;

    exp_t m_q[$];
    exp_t m_cur;
    int   m_run;

    function automatic exp_t mk(input logic [15:0] c, input logic [63:0] d, input logic b,
                                input logic dn, input logic [1:0] st, input logic rdy);
        exp_t e;
        e.code = c; e.data = d; e.busy = b; e.done = dn; e.status = st; e.ready = rdy;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a command expands into a list of per-cycle expected outputs.
    initial begin
        logic [63:0] vals [0:4];
        m_cur = mk(16'd0, 64'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        m_run = 0;
        forever begin
            @(posedge clk or posedge Reset);
            if (Reset) begin
                m_q.delete();
                m_cur = mk(16'd0, 64'd0, 1'b0, 1'b0, 2'b00, 1'b1);
                m_run = 0;
            end else begin
                if (m_cur.code >= 16'd1 && m_cur.code <= 16'd4 && cmd_abort) begin
                    m_q.delete();
                    for (int h = 0; h < H; h++) m_q.push_back(mk(16'd0, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0));
                    m_q.push_back(mk(16'd0, 64'd0, 1'b0, 1'b1, 2'b10, 1'b1));
                end else if (m_cur.ready && cmd_valid) begin
                    if (cmd_riset[63] || $signed(cmd_roset) <= 0) begin
                        m_q.push_back(mk(16'd0, 64'd0, 1'b1, 1'b1, 2'b01, 1'b0));
                    end else begin
                        vals = '{cmd_yset, cmd_rset, cmd_riset, cmd_roset, cmd_roset};
                        for (int s = 0; s < 5; s++)
                            for (int h = 0; h < H; h++)
                                m_q.push_back(mk(16'(s + 1), vals[s], 1'b1, 1'b0, 2'b00, 1'b0));
                        for (int h = 0; h < H; h++) m_q.push_back(mk(16'd0, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0));
                        m_q.push_back(mk(16'd0, 64'd0, 1'b0, 1'b1, 2'b00, 1'b1));
                    end
                end
                m_cur = (m_q.size() > 0) ? m_q.pop_front() : mk(16'd0, 64'd0, 1'b0, 1'b0, 2'b00, 1'b1);
                m_run = pulse_en ? m_run + 1 : 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("reg_control", {48'd0, reg_control}, {48'd0, m_cur.code});
            chk("reg_data", {reg_3, reg_2, reg_1, reg_0}, m_cur.data);
            chk("busy", {63'd0, busy}, {63'd0, m_cur.busy});
            chk("done", {63'd0, done}, {63'd0, m_cur.done});
            chk("status", {62'd0, status}, {62'd0, m_cur.status});
            chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, m_cur.ready && !Reset});
            chk("timepulse", {63'd0, timepulse}, {63'd0, (m_run > 0) && (m_run % PD == 0)});
        end
    end

    task automatic wait_done(input int start, output int k);
        k = start;
        while (!done && k < 80) begin
            step();
            k++;
        end
    endtask

    initial begin
        int  k;
        logic saw5;
        logic seen;
        logic tp [0:40];

        #1 Reset = 1'b1;
        step();
        step();
        chk("rst_code", {48'd0, reg_control}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        Reset = 1'b0;
        #1 chk("rel_ready", {63'd0, cmd_ready}, 64'd1);
        step();

        // 1: nominal load
        cmd_yset = 64'h0001_0002_0003_0004; cmd_rset = 64'd5; cmd_riset = 64'd1; cmd_roset = 64'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("t1_code_y", {48'd0, reg_control}, 64'd1);
        chk("t1_reg3", {48'd0, reg_3}, 64'd1);
        chk("t1_reg2", {48'd0, reg_2}, 64'd2);
        chk("t1_reg1", {48'd0, reg_1}, 64'd3);
        chk("t1_reg0", {48'd0, reg_0}, 64'd4);
        wait_done(1, k);
        chk("t1_latency", 64'(k), 64'd25);
        chk("t1_status", {62'd0, status}, 64'd0);
        chk("t1_ready", {63'd0, cmd_ready}, 64'd1);
        step();

        // 2: parameter errors (roset=0, then riset=-1)
        for (int v = 0; v < 2; v++) begin
            cmd_riset = (v == 0) ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF;
            cmd_roset = (v == 0) ? 64'd0 : 64'd2;
            cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            chk("t2_done", {63'd0, done}, 64'd1);
            chk("t2_status", {62'd0, status}, 64'd1);
            chk("t2_code", {48'd0, reg_control}, 64'd0);
            step();
            chk("t2_ready", {63'd0, cmd_ready}, 64'd1);
        end

        // 3: abort during LD_R (boundary riset=0, roset=1 accepted)
        cmd_yset = 64'hDEAD_BEEF_0123_4567; cmd_rset = 64'hFFFF_FFFF_FFFF_FFF0;
        cmd_riset = 64'd0; cmd_roset = 64'd1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        k = 1; saw5 = 1'b0;
        while (!done && k < 80) begin
            cmd_abort = (k == 6);
            if (reg_control == 16'd5) saw5 = 1'b1;
            step();
            k++;
        end
        cmd_abort = 1'b0;
        chk("t3_latency", 64'(k), 64'd11);
        chk("t3_status", {62'd0, status}, 64'd2);
        chk("t3_no_commit", {63'd0, saw5}, 64'd0);
        step();

        // 4: valid held through the load, inputs change mid-sequence, abort ignored in COMMIT
        cmd_yset = 64'h1111_2222_3333_4444; cmd_rset = 64'd7; cmd_riset = 64'd3; cmd_roset = 64'd9;
        cmd_valid = 1'b1;
        k = 0;
        while (!done && k < 80) begin
            step();
            k++;
            cmd_abort = (k == 18);
            if (k == 2) begin
                cmd_yset = 64'hAAAA_BBBB_CCCC_DDDD; cmd_rset = 64'd11;
                cmd_riset = 64'd12; cmd_roset = 64'd13;
            end
        end
        cmd_abort = 1'b0;
        chk("t4_latency", 64'(k), 64'd25);
        chk("t4_status", {62'd0, status}, 64'd0);
        step();
        cmd_valid = 1'b0;
        chk("t4_reaccept_code", {48'd0, reg_control}, 64'd1);
        chk("t4_reaccept_reg3", {48'd0, reg_3}, 64'hAAAA);
        wait_done(1, k);
        chk("t4_latency2", 64'(k), 64'd25);
        step();

        // 5: reset mid-COMMIT
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (17) step();
        chk("t5_in_commit", {48'd0, reg_control}, 64'd5);
        #2 Reset = 1'b1;
        #1;
        chk("t5_rst_code", {48'd0, reg_control}, 64'd0);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_data", {48'd0, reg_0}, 64'd0);
        chk("t5_rst_ready", {63'd0, cmd_ready}, 64'd0);
        step();
        Reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done || reg_control != 16'd0) seen = 1'b1;
        end
        chk("t5_quiet", {63'd0, seen}, 64'd0);
        chk("t5_ready", {63'd0, cmd_ready}, 64'd1);

        // 6: timepulse
        pulse_en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            tp[c] = timepulse;
            if (c == 25) pulse_en = 1'b0;
            if (c == 27) pulse_en = 1'b1;
        end
        pulse_en = 1'b0;
        chk("t6_c9", {63'd0, tp[9]}, 64'd0);
        chk("t6_c10", {63'd0, tp[10]}, 64'd1);
        chk("t6_c20", {63'd0, tp[20]}, 64'd1);
        chk("t6_c30", {63'd0, tp[30]}, 64'd0);
        chk("t6_c36", {63'd0, tp[36]}, 64'd0);
        chk("t6_c37", {63'd0, tp[37]}, 64'd1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
